// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the two-client SDRAM port arbiter.
package sdram_arb_pkg;
    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_t;

    localparam logic CLI_0 = 1'b0;
    localparam logic CLI_1 = 1'b1;
endpackage

// File: rtl/sdram_port_arbiter_rr_arb2.sv
// Two-input round-robin picker; the last-grant pointer lives in the parent.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    import sdram_arb_pkg::*;

    always_comb begin
        gnt = req;
        // On contention the client not served last wins.
        if (req == 2'b11)
            gnt = (last == CLI_1) ? 2'b01 : 2'b10;
    end
endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter between UART (client 0) and pattern engine (client 1) in
// front of the SDRAM controller. Define ARB_TIMEOUT_EN to enable BUSY timeout.
module sdram_port_arbiter #(
    parameter int ADDR_W         = sdram_arb_pkg::ADDR_W,
    parameter int DATA_W         = sdram_arb_pkg::DATA_W,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_ack,
    output logic [DATA_W-1:0] c0_rdata,
    output logic              c0_err,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_ack,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              c1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_ready,
    input  logic              mem_wr_ready,
    output logic              busy
);
    import sdram_arb_pkg::*;

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    if (GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("GAP_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_t        state;
    logic              last, win, we_q;
    logic [GW-1:0]     gap_cnt;
    logic [1:0]        req, gnt;
    logic              sel_we, done, expire;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata, cap_data;

    assign req       = {c1_req, c0_req};
    assign sel_we    = gnt[1] ? c1_we    : c0_we;
    assign sel_addr  = gnt[1] ? c1_addr  : c0_addr;
    assign sel_wdata = gnt[1] ? c1_wdata : c0_wdata;
    // Only the ready matching the issued operation completes the access.
    assign done      = we_q ? mem_wr_ready : mem_rd_ready;
    assign cap_data  = (done && !we_q) ? mem_rd_data : '0;

    rr_arb2 u_rr (.req(req), .last(last), .gnt(gnt));

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;

    assign expire = (state == ST_BUSY) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tcnt <= '0;
        else if (state != ST_BUSY)
            tcnt <= '0;
        else if (tcnt != TW'(TIMEOUT_CYCLES))
            tcnt <= tcnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c0_err <= 1'b0;
            c1_err <= 1'b0;
        end else if (state == ST_BUSY && expire && !done) begin
            c0_err <= !win;
            c1_err <= win;
        end else begin
            c0_err <= 1'b0;
            c1_err <= 1'b0;
        end
    end
`else
    assign expire = 1'b0;
    assign c0_err = 1'b0;
    assign c1_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            last        <= CLI_1;
            win         <= CLI_0;
            we_q        <= 1'b0;
            gap_cnt     <= '0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            mem_rd_req  <= 1'b0;
            mem_wr_req  <= 1'b0;
            c0_ack      <= 1'b0;
            c1_ack      <= 1'b0;
            c0_rdata    <= '0;
            c1_rdata    <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (|gnt) begin
                    win         <= gnt[1];
                    we_q        <= sel_we;
                    mem_addr    <= sel_addr;
                    mem_wr_data <= sel_wdata;
                    mem_wr_req  <= sel_we;
                    mem_rd_req  <= !sel_we;
                    busy        <= 1'b1;
                    state       <= ST_BUSY;
                end
                ST_BUSY: if (done || expire) begin
                    mem_wr_req <= 1'b0;
                    mem_rd_req <= 1'b0;
                    c0_ack     <= !win;
                    c1_ack     <= win;
                    if (win) c1_rdata <= cap_data;
                    else     c0_rdata <= cap_data;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    c0_ack   <= 1'b0;
                    c1_ack   <= 1'b0;
                    c0_rdata <= '0;
                    c1_rdata <= '0;
                    last     <= win;
                    gap_cnt  <= GW'(GAP_CYCLES - 1);
                    state    <= ST_GAP;
                end
                default: begin
                    if (gap_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: vector table plus corner sequences.
module tb_sdram_port_arbiter;
    localparam int AW = 24, DW = 16, GAP = 2;

    logic          clk = 0, rst = 1;
    logic          c0_req = 0, c0_we = 0, c1_req = 0, c1_we = 0;
    logic [AW-1:0] c0_addr = 0, c1_addr = 0;
    logic [DW-1:0] c0_wdata = 0, c1_wdata = 0;
    logic          c0_ack, c0_err, c1_ack, c1_err;
    logic [DW-1:0] c0_rdata, c1_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_req, mem_wr_req, busy;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data = 0;
    logic          mem_rd_ready = 0, mem_wr_ready = 0;

    int tests = 0, fails = 0;

    sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_ack(c0_ack), .c0_rdata(c0_rdata), .c0_err(c0_err),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_ack(c1_ack), .c1_rdata(c1_rdata), .c1_err(c1_err),
        .mem_addr(mem_addr), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .mem_rd_ready(mem_rd_ready), .mem_wr_ready(mem_wr_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          cli;
        bit          we;
        logic [23:0] addr;
        logic [15:0] wdata;
        logic [15:0] mdata;
        int          lat;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_cli(input bit c, input bit r, input bit we,
                           input logic [23:0] a, input logic [15:0] d);
        if (c) begin c1_req = r; c1_we = we; c1_addr = a; c1_wdata = d; end
        else   begin c0_req = r; c0_we = we; c0_addr = a; c0_wdata = d; end
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!(mem_wr_req || mem_rd_req) && n < 50) begin tick(); n++; end
        chk("grant_within_budget", n < 50, 1);
    endtask

    task automatic do_txn(input vec_t v);
        int n;
        bit ok;
        logic [1:0] op;
        op = v.we ? 2'b10 : 2'b01;
        set_cli(v.cli, 1, v.we, v.addr, v.wdata);
        wait_req(n);
        chk("op", {mem_wr_req, mem_rd_req}, op);
        chk("addr", mem_addr, v.addr);
        // Changing fields after grant must not reach the controller.
        set_cli(v.cli, 1, ~v.we, ~v.addr, ~v.wdata);
        ok = 1;
        for (int i = 1; i < v.lat; i++) begin
            if (mem_addr !== v.addr || (v.we && mem_wr_data !== v.wdata) ||
                {mem_wr_req, mem_rd_req} !== op || c0_ack || c1_ack) ok = 0;
            tick();
        end
        chk("busy_hold", ok, 1);
        if (v.we) chk("wdata", mem_wr_data, v.wdata);
        mem_rd_data = v.mdata;
        if (v.we) mem_wr_ready = 1; else mem_rd_ready = 1;
        tick();
        mem_wr_ready = 0; mem_rd_ready = 0;
        chk("ack", {c1_ack, c0_ack}, v.cli ? 2'b10 : 2'b01);
        chk("rdata", v.cli ? c1_rdata : c0_rdata, v.exp_rdata);
        chk("err", {c1_err, c0_err}, 0);
        chk("req_drop", {mem_wr_req, mem_rd_req}, 0);
        set_cli(v.cli, 0, 0, 0, 0);
        tick();
        chk("ack_one_cycle", {c1_ack, c0_ack}, 0);
        tick(); tick();
        chk("idle_after_gap", busy, 0);
    endtask

    task automatic do_reset();
        rst = 1;
        tick(); tick();
        rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit exp_cli;
        vecs[0] = '{0, 1, 24'h012345, 16'hBEEF, 16'h0000, 5, 16'h0000};
        vecs[1] = '{1, 0, 24'hFFFFFF, 16'h0000, 16'hA5A5, 3, 16'hA5A5};
        vecs[2] = '{0, 0, 24'h000000, 16'h1111, 16'h5A5A, 1, 16'h5A5A};
        vecs[3] = '{1, 1, 24'h800001, 16'h1234, 16'hFFFF, 2, 16'h0000};

        tick(); tick();
        chk("reset_client_outs", {c0_ack, c0_rdata, c0_err, c1_ack, c1_rdata, c1_err}, 0);
        chk("reset_mem_outs", {mem_addr, mem_rd_req, mem_wr_req, mem_wr_data, busy}, 0);
        rst = 0;
        tick();

        foreach (vecs[i]) do_txn(vecs[i]);

        // Contention from reset: c0 reads 0x10, c1 writes 0x20, both held high.
        rst = 1;
        set_cli(0, 1, 0, 24'h000010, 16'h0);
        set_cli(1, 1, 1, 24'h000020, 16'h0F0F);
        tick(); rst = 0;
        for (int t = 0; t < 4; t++) begin
            exp_cli = (t % 2) == 1;
            wait_req(n);
            if (t > 0) chk("gap_idle_cycles", (n - 1) >= GAP, 1);
            chk("rr_order_addr", mem_addr, exp_cli ? 24'h000020 : 24'h000010);
            tick();
            mem_rd_data = 16'h0C0C; mem_rd_ready = 1; mem_wr_ready = 1;
            tick();
            mem_rd_ready = 0; mem_wr_ready = 0;
            chk("rr_order_ack", {c1_ack, c0_ack}, exp_cli ? 2'b10 : 2'b01);
        end
        set_cli(0, 0, 0, 0, 0); set_cli(1, 0, 0, 0, 0);
        do_reset();
        tick();

        // Stray read-ready during a write is ignored.
        set_cli(0, 1, 1, 24'h000777, 16'h7777);
        wait_req(n);
        mem_rd_ready = 1; tick(); mem_rd_ready = 0;
        chk("stray_rd_ready_ignored", {mem_wr_req, c0_ack}, 2'b10);
        tick();
        chk("stray_still_busy", {mem_wr_req, c0_ack}, 2'b10);
        mem_wr_ready = 1; tick(); mem_wr_ready = 0;
        chk("stray_wr_completes", {mem_wr_req, c0_ack}, 2'b01);
        set_cli(0, 0, 0, 0, 0);
        tick(); tick(); tick();

        // Readies while idle produce nothing.
        mem_rd_ready = 1; mem_wr_ready = 1; tick();
        mem_rd_ready = 0; mem_wr_ready = 0; tick();
        chk("idle_ready_ignored", {c1_ack, c0_ack, busy, mem_wr_req, mem_rd_req}, 0);

        // Reset mid-BUSY drops the request at once; c0 wins afterwards.
        set_cli(1, 1, 0, 24'h0BBBBB, 16'h0);
        wait_req(n);
        chk("pre_reset_rd_req", mem_rd_req, 1);
        rst = 1; #1;
        chk("reset_drops_req", {mem_rd_req, busy}, 0);
        set_cli(0, 1, 0, 24'h0AAAAA, 16'h0);
        tick();
        chk("reset_no_ack", {c1_ack, c0_ack}, 0);
        rst = 0;
        wait_req(n);
        chk("post_reset_c0_first", mem_addr, 24'h0AAAAA);
        set_cli(0, 0, 0, 0, 0); set_cli(1, 0, 0, 0, 0);
        do_reset();
        tick();

`ifdef ARB_TIMEOUT_EN
        // No ready: abort after 16 BUSY cycles.
        mem_rd_data = 16'hDEAD;
        set_cli(0, 1, 0, 24'h000042, 16'h0);
        wait_req(n);
        n = 0;
        while (!c0_ack && n < 40) begin tick(); n++; end
        chk("timeout_cycles", n, 16);
        chk("timeout_err", c0_err, 1);
        chk("timeout_rdata", c0_rdata, 0);
        chk("timeout_req_drop", mem_rd_req, 0);
        set_cli(0, 0, 0, 0, 0);
        tick(); tick(); tick();

        // Ready on the expiry cycle completes normally.
        set_cli(0, 1, 0, 24'h000043, 16'h0);
        wait_req(n);
        repeat (15) tick();
        mem_rd_data = 16'h1234; mem_rd_ready = 1;
        tick();
        mem_rd_ready = 0;
        chk("expiry_ready_ack", c0_ack, 1);
        chk("expiry_ready_err", c0_err, 0);
        chk("expiry_ready_rdata", c0_rdata, 16'h1234);
        set_cli(0, 0, 0, 0, 0);
        tick(); tick(); tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Two-client, round-robin arbiter in front of the single-word SDRAM controller's command interface (addr/rd_req/wr_req/wr_data, rd_data/rd_ready/wr_ready).
- Client 0 is the UART command path; client 1 is the test/pattern engine.
- Serialises requests, holds the level-sensitive controller request stable until the controller's completion pulse, then returns a one-cycle acknowledge with read data to the winning client.

Parameters:
- ADDR_W, 24, word address width; matches the controller's bank/row/column split.
- DATA_W, 16, data word width.
- GAP_CYCLES, 2, idle cycles enforced after each completion before the next grant; must be at least 1.
- TIMEOUT_CYCLES, 4096, BUSY cycles before abort; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- c0_req  in  1  client 0 request level; held until c0_ack.
- c0_we  in  1  1 = write, 0 = read.
- c0_addr  in  ADDR_W  word address.
- c0_wdata  in  DATA_W  write data.
- c0_ack  out  1  one-cycle completion pulse.
- c0_rdata  out  DATA_W  read data; valid while c0_ack is high.
- c0_err  out  1  completion was a timeout abort; valid while c0_ack is high.
- c1_req, c1_we, c1_addr, c1_wdata, c1_ack, c1_rdata, c1_err: same as client 0.
- mem_addr  out  ADDR_W  to controller addr.
- mem_rd_req  out  1  to controller rd_req.
- mem_wr_req  out  1  to controller wr_req.
- mem_wr_data  out  DATA_W  to controller wr_data.
- mem_rd_data  in  DATA_W  from controller rd_data.
- mem_rd_ready  in  1  controller read-complete pulse.
- mem_wr_ready  in  1  controller write-complete pulse.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Round-robin pointer gives client 0 priority.
  - Gap counter is 0.
  - Reset asserted mid-transaction drops mem_*_req immediately; no ack is issued for the aborted transaction.
- State machine: IDLE -> BUSY -> RESP -> GAP -> IDLE. All outputs are registered.
- IDLE arbitration:
  - If exactly one client has req high, that client wins.
  - If both have req high, the client not served last wins.
  - On the grant edge, register winner id, we, addr and wdata into mem_addr, mem_wr_data and an internal we flag.
  - Assert exactly one of mem_wr_req / mem_rd_req from the next cycle; move to BUSY.
  - Grant latency: req sampled at edge k gives mem request visible after edge k.
- BUSY:
  - mem request and mem_addr / mem_wr_data are held constant.
  - mem_rd_req and mem_wr_req are never high together.
  - Only the ready matching the issued operation is accepted; the other ready and any ready seen in IDLE, RESP or GAP are ignored.
  - On the accepted ready: clear the mem request, capture mem_rd_data (reads only), go to RESP.
- RESP (one cycle):
  - Winner's ack = 1.
  - rdata = captured data for reads, 0 for writes.
  - err = 0.
  - Loser's ack stays 0.
  - Update pointer to the winner.
- GAP:
  - Hold GAP_CYCLES cycles with no mem request, so the controller returns to its idle state before it samples a new level.
  - Then go to IDLE.
- Client rules:
  - A client drops req on the cycle after ack, or keeps it high to queue another access.
  - A kept-high req re-arbitrates normally.
  - Client command fields are sampled only at grant; later changes before ack are ignored.
- Ack rate: at most one ack per transaction; at most one transaction every (3 + GAP_CYCLES + controller latency) cycles.
- Address and data pass through unmodified; no width conversion.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A BUSY cycle counter saturates at TIMEOUT_CYCLES.
  - On reaching it: drop the mem request, go to RESP with ack = 1, err = 1, rdata = 0.
  - A ready arriving in the same cycle as expiry wins: normal completion, err = 0.
  - Counter clears on each grant.
- Not defined: no counter logic; BUSY waits indefinitely; c0_err and c1_err are tied to 0.

Decomposition:
- Package sdram_arb_pkg:
  - State encoding constants ST_IDLE, ST_BUSY, ST_RESP, ST_GAP.
  - Client id constants CLI_0, CLI_1.
  - Default widths ADDR_W = 24, DATA_W = 16.
- Sub-module rr_arb2: two-input round-robin picker with last-grant pointer input and one-hot grant output; purely combinational, with the pointer register held in the parent.

Test Plan:
- Single write: c0 write addr 0x012345, data 0xBEEF; mem_wr_ready pulsed 5 cycles after mem_wr_req -> mem_addr = 0x012345, mem_wr_data = 0xBEEF held until ready; c0_ack 1 cycle, c0_err = 0; mem_wr_req low the cycle after ready.
- Single read: c1 read addr 0xFFFFFF; model returns 0xA5A5 with mem_rd_ready -> c1_ack with c1_rdata = 0xA5A5; mem_wr_req never asserted.
- Contention:
  - Both req high from reset -> service order c0, c1, c0, c1 over 4 transactions.
  - Grants separated by at least GAP_CYCLES idle cycles with no mem request.
- Stray ready:
  - mem_rd_ready pulsed during a write BUSY -> ignored; completes only on mem_wr_ready.
  - Ready pulsed in IDLE -> no ack.
- Reset mid-BUSY: assert rst while mem_rd_req is high -> mem_rd_req low immediately; no ack; next grant goes to c0 first.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, no ready from the model -> ack with err = 1, rdata = 0 after 16 BUSY cycles. Ready on the expiry cycle -> err = 0 with real data.
